// File: rtl/moldudp64_unpacker.sv
// MoldUDP64 downstream packet unpacker.
// Strips the MoldUDP64 header and the per-message length prefixes, forwards
// bare ITCH message bytes one cycle after they arrive, and tracks the
// sequence number.
// A sequence gap, a malformed length or a truncated datagram raises a
// one-cycle packetLostOut pulse. Duplicate or stale packets are dropped
// silently and counted.
module moldudp64_unpacker #(
  parameter int MAX_MSG_LEN   = 64,
  parameter int SESSION_BYTES = 10
) (
  input  logic        clkIn,
  input  logic        rstIn,
  input  logic [7:0]  dataIn,
  input  logic        dataValidIn,
  output logic [7:0]  dataOut,
  output logic        dataValidOut,
  output logic        packetLostOut,
  output logic [63:0] expSeqNumOut,
  output logic [15:0] dropCntOut
);

  typedef enum logic [2:0] {
    IDLE,
    SESSION,
    SEQ,
    COUNT,
    LEN_HI,
    LEN_LO,
    PAYLOAD,
    DRAIN
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  hdrIdx_q, hdrIdx_d;
  logic [63:0] seq_q, seq_d;
  logic [7:0]  cntHi_q, cntHi_d;
  logic [7:0]  lenHi_q, lenHi_d;
  logic [15:0] remaining_q, remaining_d;
  logic [15:0] byteCnt_q, byteCnt_d;
  logic        synced_q, synced_d;
  logic [63:0] expected_q, expected_d;
  logic [15:0] dropCnt_q, dropCnt_d;
  logic [7:0]  dataOut_q, dataOut_d;
  logic        dataValidOut_q, dataValidOut_d;
  logic        packetLost_q, packetLost_d;

  logic [15:0] msgCnt;
  logic [15:0] lenField;
  logic        inPacket;
  logic        truncate;
  logic        lastSession;
  logic        lastSeq;
  logic        secondCnt;
  logic        endSession;
  logic        isStale;
  logic        isGap;
  logic        accept;
  logic        lenZero;
  logic        lenTooBig;
  logic        lastMsg;
  logic        lastByte;
  logic        bumpDrop;

  // Both 16-bit header fields complete with the byte currently on dataIn.
  assign msgCnt      = {cntHi_q, dataIn};
  assign lenField    = {lenHi_q, dataIn};

  // Any state that still expects more bytes of this datagram.
  assign inPacket    = (state_q != IDLE) && (state_q != DRAIN);
  assign truncate    = inPacket && !dataValidIn;

  assign lastSession = (hdrIdx_q == 8'(SESSION_BYTES - 1));
  assign lastSeq     = (hdrIdx_q == 8'd7);
  assign secondCnt   = (hdrIdx_q == 8'd1);

  // Sequence decision, evaluated on the second message-count byte.
  // Stale and gap checks only apply once a session has been synced.
  assign endSession  = (msgCnt == 16'hFFFF);
  assign isStale     = synced_q && (seq_q < expected_q);
  assign isGap       = synced_q && (seq_q > expected_q);
  assign accept      = !endSession && !isStale;

  assign lenZero     = (lenField == 16'd0);
  assign lenTooBig   = (lenField > 16'(MAX_MSG_LEN));
  assign lastMsg     = (remaining_q == 16'd1);
  assign lastByte    = (byteCnt_q == 16'd1);

  // State register, cleared asynchronously so a mid-packet reset restarts from IDLE.
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A falling dataValidIn inside a datagram always aborts to IDLE.
  always_comb begin
    state_d = state_q;
    if (truncate) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (dataValidIn) state_d = SESSION;
        SESSION: if (lastSession) state_d = SEQ;
        SEQ:     if (lastSeq) state_d = COUNT;
        COUNT:   if (secondCnt) state_d = (accept && (msgCnt != 16'd0)) ? LEN_HI : DRAIN;
        LEN_HI:  state_d = LEN_LO;
        LEN_LO: begin
          if (lenZero) begin
            state_d = lastMsg ? DRAIN : LEN_HI;
          end else if (lenTooBig) begin
            state_d = DRAIN;
          end else begin
            state_d = PAYLOAD;
          end
        end
        PAYLOAD: if (lastByte) state_d = lastMsg ? DRAIN : LEN_HI;
        DRAIN:   if (!dataValidIn) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath and registered-output next values.
  // dataValidOut defaults low, so the length bytes always leave a two-cycle
  // hole between consecutive messages.
  always_comb begin
    hdrIdx_d       = hdrIdx_q;
    seq_d          = seq_q;
    cntHi_d        = cntHi_q;
    lenHi_d        = lenHi_q;
    remaining_d    = remaining_q;
    byteCnt_d      = byteCnt_q;
    synced_d       = synced_q;
    expected_d     = expected_q;
    dataOut_d      = dataOut_q;
    dataValidOut_d = 1'b0;
    packetLost_d   = 1'b0;
    bumpDrop       = 1'b0;

    if (truncate) begin
      packetLost_d = 1'b1;
      bumpDrop     = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (dataValidIn) hdrIdx_d = 8'd1;
        end
        SESSION: begin
          hdrIdx_d = lastSession ? 8'd0 : hdrIdx_q + 8'd1;
        end
        SEQ: begin
          seq_d    = {seq_q[55:0], dataIn};
          hdrIdx_d = lastSeq ? 8'd0 : hdrIdx_q + 8'd1;
        end
        COUNT: begin
          if (!secondCnt) begin
            cntHi_d  = dataIn;
            hdrIdx_d = 8'd1;
          end else begin
            hdrIdx_d = 8'd0;
            if (endSession) begin
              synced_d = 1'b0;
            end else if (isStale) begin
              bumpDrop = 1'b1;
            end else begin
              // Unsynced, gap and in-order packets all re-anchor on this
              // packet's sequence number; for an in-order packet that equals
              // the current expectation anyway.
              packetLost_d = isGap;
              synced_d     = 1'b1;
              expected_d   = seq_q + 64'(msgCnt);
              remaining_d  = msgCnt;
            end
          end
        end
        LEN_HI: begin
          lenHi_d = dataIn;
        end
        LEN_LO: begin
          if (lenZero) begin
            remaining_d = remaining_q - 16'd1;
          end else if (lenTooBig) begin
            packetLost_d = 1'b1;
            bumpDrop     = 1'b1;
          end else begin
            byteCnt_d = lenField;
          end
        end
        PAYLOAD: begin
          dataOut_d      = dataIn;
          dataValidOut_d = 1'b1;
          byteCnt_d      = byteCnt_q - 16'd1;
          if (lastByte) remaining_d = remaining_q - 16'd1;
        end
        default: begin
        end
      endcase
    end

    dropCnt_d = (bumpDrop && (dropCnt_q != 16'hFFFF)) ? dropCnt_q + 16'd1 : dropCnt_q;
  end

  // Datapath registers; every output is cleared the moment reset rises.
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      hdrIdx_q       <= 8'd0;
      seq_q          <= 64'd0;
      cntHi_q        <= 8'd0;
      lenHi_q        <= 8'd0;
      remaining_q    <= 16'd0;
      byteCnt_q      <= 16'd0;
      synced_q       <= 1'b0;
      expected_q     <= 64'd0;
      dropCnt_q      <= 16'd0;
      dataOut_q      <= 8'd0;
      dataValidOut_q <= 1'b0;
      packetLost_q   <= 1'b0;
    end else begin
      hdrIdx_q       <= hdrIdx_d;
      seq_q          <= seq_d;
      cntHi_q        <= cntHi_d;
      lenHi_q        <= lenHi_d;
      remaining_q    <= remaining_d;
      byteCnt_q      <= byteCnt_d;
      synced_q       <= synced_d;
      expected_q     <= expected_d;
      dropCnt_q      <= dropCnt_d;
      dataOut_q      <= dataOut_d;
      dataValidOut_q <= dataValidOut_d;
      packetLost_q   <= packetLost_d;
    end
  end

  assign dataOut       = dataOut_q;
  assign dataValidOut  = dataValidOut_q;
  assign packetLostOut = packetLost_q;
  assign expSeqNumOut  = expected_q;
  assign dropCntOut    = dropCnt_q;

endmodule

// File: tb/tb_moldudp64_unpacker.sv
// Testbench for moldudp64_unpacker.
// Packets are built as byte arrays. A packet-level model walks each datagram
// and predicts, for every cycle, what the outputs must show. A single
// compare process checks the outputs against that prediction on every clock.
module tb_moldudp64_unpacker;

  localparam int MAX_LEN = 64;
  localparam int HDR     = 20;

  logic        clkIn = 1'b0;
  logic        rstIn;
  logic [7:0]  dataIn;
  logic        dataValidIn;
  logic [7:0]  dataOut;
  logic        dataValidOut;
  logic        packetLostOut;
  logic [63:0] expSeqNumOut;
  logic [15:0] dropCntOut;

  always #5 clkIn = ~clkIn;

  moldudp64_unpacker #(
    .MAX_MSG_LEN  (MAX_LEN),
    .SESSION_BYTES(10)
  ) dut (
    .clkIn        (clkIn),
    .rstIn        (rstIn),
    .dataIn       (dataIn),
    .dataValidIn  (dataValidIn),
    .dataOut      (dataOut),
    .dataValidOut (dataValidOut),
    .packetLostOut(packetLostOut),
    .expSeqNumOut (expSeqNumOut),
    .dropCntOut   (dropCntOut)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  pkt     [0:511];
  int          pktLen;
  logic        trValid [0:511];
  logic [7:0]  trData  [0:511];
  logic        trPulse [0:511];
  logic [63:0] trExp   [0:511];
  logic [15:0] trDrop  [0:511];
  int          trLen = 0;

  logic        mSynced;
  logic [63:0] mExp;
  logic [15:0] mDrop;

  int  edgeCnt   = 0;
  int  traceBase = 1 << 30;
  bit  chkOn     = 1'b0;
  int  cmpK;
  logic        eValid, ePulse;
  logic [7:0]  eData;
  logic [63:0] eExp;
  logic [15:0] eDrop;

  int outBytes    = 0;
  int pulseCnt    = 0;
  int firstValidK = -1;
  int lastValidK  = -1;
  int lastPulseK  = -1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic pushByte(input logic [7:0] b);
    pkt[pktLen] = b;
    pktLen++;
  endtask

  task automatic startPacket(input logic [63:0] seq, input logic [15:0] cnt);
    pktLen = 0;
    for (int i = 0; i < 10; i++) pushByte(8'(65 + i));
    for (int i = 7; i >= 0; i--) pushByte(seq[i*8 +: 8]);
    pushByte(cnt[15:8]);
    pushByte(cnt[7:0]);
  endtask

  task automatic addMsg(input logic [15:0] len, input int nBytes, input int seed);
    pushByte(len[15:8]);
    pushByte(len[7:0]);
    for (int i = 0; i < nBytes; i++) pushByte(8'(seed * 7 + i * 13 + 1));
  endtask

  task automatic addRaw(input int n);
    for (int i = 0; i < n; i++) pushByte(8'(224 + i));
  endtask

  task automatic bumpDrop(input int k);
    if (mDrop != 16'hFFFF) mDrop++;
    for (int i = k; i <= trLen; i++) trDrop[i] = mDrop;
  endtask

  task automatic markTrunc();
    trPulse[pktLen] = 1'b1;
    bumpDrop(pktLen);
  endtask

  // Packet-level model: trace index k is what the outputs show right after
  // the clock edge that sampled byte k; index pktLen is the first idle cycle.
  task automatic runModel();
    logic [63:0] seq;
    logic [15:0] cnt;
    logic [15:0] len;
    int          p;
    trLen = pktLen;
    for (int i = 0; i <= pktLen; i++) begin
      trValid[i] = 1'b0;
      trData[i]  = 8'd0;
      trPulse[i] = 1'b0;
      trExp[i]   = mExp;
      trDrop[i]  = mDrop;
    end
    if (pktLen < HDR) begin
      markTrunc();
      return;
    end
    seq = 64'd0;
    for (int i = 10; i < 18; i++) seq = {seq[55:0], pkt[i]};
    cnt = {pkt[18], pkt[19]};
    if (cnt == 16'hFFFF) begin
      mSynced = 1'b0;
      return;
    end
    if (mSynced && seq < mExp) begin
      bumpDrop(HDR - 1);
      return;
    end
    if (mSynced && seq > mExp) trPulse[HDR-1] = 1'b1;
    mSynced = 1'b1;
    mExp    = seq + 64'(cnt);
    for (int i = HDR - 1; i <= pktLen; i++) trExp[i] = mExp;
    p = HDR;
    for (int m = 0; m < int'(cnt); m++) begin
      if (p + 2 > pktLen) begin
        markTrunc();
        return;
      end
      len = {pkt[p], pkt[p+1]};
      p += 2;
      if (len == 16'd0) continue;
      if (int'(len) > MAX_LEN) begin
        trPulse[p-1] = 1'b1;
        bumpDrop(p - 1);
        return;
      end
      for (int b = 0; b < int'(len); b++) begin
        if (p >= pktLen) begin
          markTrunc();
          return;
        end
        trValid[p] = 1'b1;
        trData[p]  = pkt[p];
        p++;
      end
    end
  endtask

  // Drives the packet currently in pkt[] after loading the model's prediction.
  task automatic applyStimulus();
    @(negedge clkIn);
    runModel();
    traceBase   = edgeCnt + 1;
    outBytes    = 0;
    pulseCnt    = 0;
    firstValidK = -1;
    lastValidK  = -1;
    lastPulseK  = -1;
    for (int j = 0; j < pktLen; j++) begin
      dataIn      = pkt[j];
      dataValidIn = 1'b1;
      @(negedge clkIn);
    end
    dataValidIn = 1'b0;
    dataIn      = 8'd0;
    repeat (4) @(negedge clkIn);
  endtask

  // Per-cycle compare against the model trace, plus per-packet statistics.
  always @(posedge clkIn) begin
    edgeCnt++;
    #1;
    if (chkOn) begin
      cmpK = edgeCnt - traceBase;
      if (cmpK >= 0 && cmpK <= trLen) begin
        eValid = trValid[cmpK];
        eData  = trData[cmpK];
        ePulse = trPulse[cmpK];
        eExp   = trExp[cmpK];
        eDrop  = trDrop[cmpK];
      end else begin
        eValid = 1'b0;
        eData  = 8'd0;
        ePulse = 1'b0;
        eExp   = mExp;
        eDrop  = mDrop;
      end
      checkOutput("dataValidOut", 64'(dataValidOut), 64'(eValid));
      if (eValid) checkOutput("dataOut", 64'(dataOut), 64'(eData));
      checkOutput("packetLostOut", 64'(packetLostOut), 64'(ePulse));
      checkOutput("expSeqNumOut", expSeqNumOut, eExp);
      checkOutput("dropCntOut", 64'(dropCntOut), 64'(eDrop));
      if (dataValidOut) begin
        outBytes++;
        if (firstValidK < 0) firstValidK = cmpK;
        lastValidK = cmpK;
      end
      if (packetLostOut) begin
        pulseCnt++;
        lastPulseK = cmpK;
      end
    end
  end

  initial begin
    rstIn       = 1'b1;
    dataIn      = 8'd0;
    dataValidIn = 1'b0;
    mSynced     = 1'b0;
    mExp        = 64'd0;
    mDrop       = 16'd0;
    pktLen      = 0;

    #12;
    checkOutput("reset dataValidOut", 64'(dataValidOut), 64'd0);
    checkOutput("reset dataOut", 64'(dataOut), 64'd0);
    checkOutput("reset packetLostOut", 64'(packetLostOut), 64'd0);
    checkOutput("reset expSeqNumOut", expSeqNumOut, 64'd0);
    checkOutput("reset dropCntOut", 64'(dropCntOut), 64'd0);
    @(negedge clkIn);
    rstIn = 1'b0;
    chkOn = 1'b1;
    repeat (2) @(negedge clkIn);

    $display("[TB] sync packet");
    startPacket(64'd100, 16'd2);
    addMsg(16'd36, 36, 1);
    addMsg(16'd19, 19, 2);
    applyStimulus();
    checkOutput("sync expSeq", expSeqNumOut, 64'd102);
    checkOutput("sync bytes", 64'(outBytes), 64'd55);
    checkOutput("sync pulses", 64'(pulseCnt), 64'd0);
    checkOutput("sync firstValid", 64'(firstValidK), 64'd22);
    checkOutput("sync lastValid", 64'(lastValidK), 64'd78);

    $display("[TB] gap packet");
    startPacket(64'd105, 16'd1);
    addMsg(16'd20, 20, 3);
    addRaw(3);
    applyStimulus();
    checkOutput("gap pulses", 64'(pulseCnt), 64'd1);
    checkOutput("gap pulse cycle", 64'(lastPulseK), 64'd19);
    checkOutput("gap expSeq", expSeqNumOut, 64'd106);
    checkOutput("gap bytes", 64'(outBytes), 64'd20);

    $display("[TB] duplicate packet");
    startPacket(64'd103, 16'd1);
    addMsg(16'd5, 5, 4);
    applyStimulus();
    checkOutput("dup bytes", 64'(outBytes), 64'd0);
    checkOutput("dup dropCnt", 64'(dropCntOut), 64'd1);
    checkOutput("dup expSeq", expSeqNumOut, 64'd106);

    $display("[TB] heartbeat and end of session");
    startPacket(64'd106, 16'd0);
    applyStimulus();
    checkOutput("hb pulses", 64'(pulseCnt), 64'd0);
    checkOutput("hb expSeq", expSeqNumOut, 64'd106);
    startPacket(64'd500, 16'hFFFF);
    addRaw(4);
    applyStimulus();
    checkOutput("eos pulses", 64'(pulseCnt), 64'd0);
    startPacket(64'd1, 16'd3);
    addMsg(16'd4, 4, 5);
    addMsg(16'd0, 0, 0);
    addMsg(16'd6, 6, 6);
    applyStimulus();
    checkOutput("resync pulses", 64'(pulseCnt), 64'd0);
    checkOutput("resync expSeq", expSeqNumOut, 64'd4);
    checkOutput("resync bytes", 64'(outBytes), 64'd10);

    $display("[TB] truncation");
    startPacket(64'd4, 16'd1);
    addMsg(16'd36, 10, 7);
    applyStimulus();
    checkOutput("trunc bytes", 64'(outBytes), 64'd10);
    checkOutput("trunc pulses", 64'(pulseCnt), 64'd1);
    checkOutput("trunc pulse cycle", 64'(lastPulseK), 64'd32);
    checkOutput("trunc dropCnt", 64'(dropCntOut), 64'd2);
    startPacket(64'd5, 16'd1);
    addMsg(16'd8, 8, 8);
    applyStimulus();
    checkOutput("post-trunc expSeq", expSeqNumOut, 64'd6);
    checkOutput("post-trunc bytes", 64'(outBytes), 64'd8);

    $display("[TB] malformed length");
    startPacket(64'd6, 16'd2);
    addMsg(16'h0100, 4, 9);
    applyStimulus();
    checkOutput("malformed pulses", 64'(pulseCnt), 64'd1);
    checkOutput("malformed pulse cycle", 64'(lastPulseK), 64'd21);
    checkOutput("malformed dropCnt", 64'(dropCntOut), 64'd3);
    checkOutput("malformed bytes", 64'(outBytes), 64'd0);

    startPacket(64'd10, 16'd2);
    addMsg(16'd3, 3, 10);
    addMsg(16'd100, 4, 11);
    applyStimulus();
    checkOutput("gap+malformed pulses", 64'(pulseCnt), 64'd2);
    checkOutput("gap+malformed last pulse", 64'(lastPulseK), 64'd26);
    checkOutput("gap+malformed dropCnt", 64'(dropCntOut), 64'd4);
    checkOutput("gap+malformed bytes", 64'(outBytes), 64'd3);
    checkOutput("gap+malformed expSeq", expSeqNumOut, 64'd12);

    startPacket(64'd12, 16'd1);
    addMsg(16'd64, 64, 12);
    applyStimulus();
    checkOutput("max-len bytes", 64'(outBytes), 64'd64);
    checkOutput("max-len expSeq", expSeqNumOut, 64'd13);

    startPacket(64'd13, 16'd1);
    pktLen = 15;
    applyStimulus();
    checkOutput("short header pulses", 64'(pulseCnt), 64'd1);
    checkOutput("short header dropCnt", 64'(dropCntOut), 64'd5);

    $display("[TB] sequence wrap");
    startPacket(64'hFFFF_FFFF_FFFF_FFFF, 16'd2);
    addMsg(16'd1, 1, 13);
    addMsg(16'd1, 1, 14);
    applyStimulus();
    checkOutput("wrap expSeq", expSeqNumOut, 64'd1);
    checkOutput("wrap pulses", 64'(pulseCnt), 64'd1);

    $display("[TB] async reset mid-payload");
    startPacket(64'd1, 16'd1);
    addMsg(16'd36, 36, 15);
    @(negedge clkIn);
    chkOn = 1'b0;
    for (int j = 0; j < 25; j++) begin
      dataIn      = pkt[j];
      dataValidIn = 1'b1;
      @(negedge clkIn);
    end
    checkOutput("pre-reset dataValidOut", 64'(dataValidOut), 64'd1);
    checkOutput("pre-reset expSeq", expSeqNumOut, 64'd2);
    #2;
    rstIn       = 1'b1;
    dataValidIn = 1'b0;
    dataIn      = 8'd0;
    #1;
    checkOutput("async reset dataValidOut", 64'(dataValidOut), 64'd0);
    checkOutput("async reset dataOut", 64'(dataOut), 64'd0);
    checkOutput("async reset expSeq", expSeqNumOut, 64'd0);
    checkOutput("async reset dropCnt", 64'(dropCntOut), 64'd0);
    checkOutput("async reset packetLost", 64'(packetLostOut), 64'd0);
    repeat (2) @(negedge clkIn);
    rstIn     = 1'b0;
    mSynced   = 1'b0;
    mExp      = 64'd0;
    mDrop     = 16'd0;
    traceBase = 1 << 30;
    chkOn     = 1'b1;
    repeat (2) @(negedge clkIn);

    startPacket(64'd50, 16'd1);
    addMsg(16'd2, 2, 16);
    applyStimulus();
    checkOutput("post-reset expSeq", expSeqNumOut, 64'd51);
    checkOutput("post-reset pulses", 64'(pulseCnt), 64'd0);
    checkOutput("post-reset bytes", 64'(outBytes), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/moldudp64_unpacker.md
Name: moldudp64_unpacker

Overview:
- Sits directly upstream of the ITCH parser. Consumes the UDP payload byte stream of MoldUDP64 downstream packets from the Ethernet/UDP receive stage.
- Strips the 20-byte MoldUDP64 header and each 2-byte message-length prefix, and forwards bare ITCH message bytes to the parser.
- Checks sequence numbers, flags gaps on packetLostOut and silently drops duplicate/stale packets.

Parameters:
MAX_MSG_LEN, 64, largest legal message length in bytes; a larger length field is treated as malformed.
SESSION_BYTES, 10, session field width in bytes; the content is ignored.

Ports:
clkIn  input  1  system clock
rstIn  input  1  asynchronous active-high reset
dataIn  input  8  UDP payload byte
dataValidIn  input  1  high for each payload byte; contiguous within a datagram; low ≥2 cycles between datagrams
dataOut  output  8  ITCH message byte
dataValidOut  output  1  high for each forwarded message byte
packetLostOut  output  1  one-cycle pulse on sequence gap or malformed/truncated packet
expSeqNumOut  output  64  next expected sequence number
dropCntOut  output  16  count of dropped packets (duplicates plus malformed); saturates at 0xFFFF

Behaviour:
- Reset (asynchronous, rstIn high): all outputs 0; state IDLE; synced flag cleared.
- Latency: dataOut/dataValidOut are registered, 1 cycle after the corresponding dataIn/dataValidIn.
- FSM states: IDLE, SESSION, SEQ, COUNT, LEN_HI, LEN_LO, PAYLOAD, DRAIN.
  - IDLE: the first valid byte is session byte 0 -> SESSION.
  - SESSION: after SESSION_BYTES bytes total -> SEQ.
  - SEQ: 8 bytes captured big-endian into seq -> COUNT.
  - COUNT: 2 bytes big-endian into msgCnt. Decision is made on the 2nd COUNT byte.
- Decision, applied in this order:
  1. msgCnt == 0xFFFF (end of session): clear synced -> DRAIN. No output, no pulse.
  2. !synced: expected := seq; synced := 1; accept.
  3. seq < expected: dropCnt++ -> DRAIN.
  4. seq > expected: packetLostOut pulse; expected := seq; accept.
  5. Otherwise: accept.
- Accept with msgCnt == 0 (heartbeat): -> DRAIN, expected unchanged. Accept with msgCnt > 0: -> LEN_HI; expected += msgCnt; the update is visible on expSeqNumOut the cycle after the 2nd COUNT byte.
- LEN_HI, LEN_LO: capture the 16-bit length.
  - len == 0: skip the message. Decrement remaining; go to LEN_HI if remaining > 0, else DRAIN.
  - len > MAX_MSG_LEN: malformed -> DRAIN.
  - Otherwise -> PAYLOAD.
- PAYLOAD: forward each byte with dataValidOut = 1 and decrement the byte counter. After the last byte, decrement the message counter, then go to LEN_HI if messages remain, else DRAIN.
- dataValidOut is low during the length bytes. This guarantees ≥2 idle cycles between consecutive messages, which is the parser's per-message realignment boundary.
- DRAIN: discard bytes until dataValidIn is low, then go to IDLE. Trailing bytes after the last message are discarded silently.
- Malformed (len > MAX_MSG_LEN): packetLostOut pulse, dropCnt++, -> DRAIN. Messages already forwarded stay forwarded. expected is not rewound.
- Truncation: dataValidIn falls in any state other than IDLE/DRAIN while a header/message is incomplete. Response: packetLostOut pulse, dropCnt++, -> IDLE. dataValidOut stays low from that cycle onward, so no partial byte follows.
- Simultaneous events: a gap pulse and a truncation within one packet produce two separate pulses. A gap and a malformed length in the same packet also produce two pulses.
- Counter widths:
  - expected is 64-bit and wraps modulo 2^64.
  - Remaining-message counter is 16-bit; byte counter is 16-bit.
  - dropCnt saturates at 0xFFFF.
- Reset mid-packet: immediate return to IDLE, outputs 0. Remaining bytes of that datagram are parsed as a new header. Because synced is cleared on reset, the bench must hold dataValidIn low across reset release.

Test Plan:
- Sync: packet seq=100, count=2, lengths 36 and 19 (an add message and a delete message) -> 55 bytes out, dataValidOut low for exactly 2 cycles between the messages, expSeqNumOut=102, no pulse.
- Gap: next packet seq=105, count=1 -> packetLostOut pulse the cycle after the 2nd COUNT byte, message forwarded, expSeqNumOut=106.
- Duplicate: packet seq=103 after expected=106 -> no dataValidOut, dropCntOut=1, expSeqNumOut unchanged at 106.
- Heartbeat and end of session:
  - count=0, seq=106 -> no output, no pulse.
  - count=0xFFFF -> synced cleared; a following packet with seq=1 is accepted with no pulse and expSeqNumOut = 1 + its count.
- Truncation: dataValidIn drops after 10 of 36 payload bytes -> 10 bytes out, pulse, dropCntOut+1, and the next datagram is parsed correctly from IDLE.
- Malformed and reset:
  - len=0x0100 -> pulse, DRAIN, no bytes out.
  - Async rstIn asserted mid-PAYLOAD -> all outputs 0 immediately, without waiting for a clock edge.
